// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction-memory address and presents
// pc / instruction / interrupt-bubble to the fetch/decode pipeline buffer.
// Handles boot-vector load, branch redirect, stall and interrupt entry.
module fetch_unit #(
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = {ADDR_W{1'b0}},
    parameter logic [ADDR_W-1:0] INT_VEC_ADDR   = {{(ADDR_W-1){1'b0}}, 1'b1},
    parameter logic [31:0]       NOP_INSTR      = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              in_INT,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [ADDR_W-1:0] o_pc,
    output logic [31:0]       o_instruction,
    output logic              out_INT,
    output logic              o_busy
);

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        INT_VEC = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic              int_pending_r;
    logic              int_pending_next_s;
    logic              bubble_s;

    // Next-state, next-PC and combinational outputs, decoded from the current state.
    always_comb begin
        state_next_s  = state_r;
        pc_next_s     = pc_r;
        bubble_s      = 1'b0;
        imem_addr     = pc_r;
        o_pc          = pc_r;
        o_instruction = NOP_INSTR;
        out_INT       = 1'b0;
        o_busy        = 1'b0;
        case (state_r)
            BOOT: begin
                imem_addr    = RESET_VEC_ADDR;
                o_pc         = {ADDR_W{1'b0}};
                o_busy       = 1'b1;
                pc_next_s    = imem_data[ADDR_W-1:0];
                state_next_s = RUN;
            end
            RUN: begin
                o_instruction = imem_data;
                if (redirect) begin
                    // Wrong-path instruction is flushed downstream; pending interrupt waits.
                    pc_next_s = redirect_pc;
                end else if (stall) begin
                    pc_next_s = pc_r;
                end else if (int_pending_r) begin
                    // Bubble carries the return address; the instruction at pc is replayed later.
                    bubble_s      = 1'b1;
                    o_instruction = NOP_INSTR;
                    out_INT       = 1'b1;
                    state_next_s  = INT_VEC;
                end else begin
                    pc_next_s = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            INT_VEC: begin
                // stall and redirect have no effect while fetching the handler vector.
                imem_addr    = INT_VEC_ADDR;
                o_busy       = 1'b1;
                pc_next_s    = imem_data[ADDR_W-1:0];
                state_next_s = RUN;
            end
            default: begin
                state_next_s = BOOT;
                pc_next_s    = {ADDR_W{1'b0}};
                o_busy       = 1'b1;
            end
        endcase
        // A new request on the bubble edge re-arms pending so a second entry follows.
        if (in_INT) begin
            int_pending_next_s = 1'b1;
        end else if (bubble_s) begin
            int_pending_next_s = 1'b0;
        end else begin
            int_pending_next_s = int_pending_r;
        end
    end

    // State, PC and pending-interrupt registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= BOOT;
            pc_r          <= {ADDR_W{1'b0}};
            int_pending_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            int_pending_r <= int_pending_next_s;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit. Memory model: word 0 holds the
// boot PC (0x10), word 1 the handler PC (0x200), every other word reads as
// 32'hC000_0000 | addr.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        in_INT;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] o_pc;
    logic [31:0] o_instruction;
    logic        out_INT;
    logic        o_busy;

    int checks;
    int errors;

    localparam logic [31:0] BOOT_PC = 32'h0000_0010;
    localparam logic [31:0] ISR_PC  = 32'h0000_0200;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .in_INT        (in_INT),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .o_pc          (o_pc),
        .o_instruction (o_instruction),
        .out_INT       (out_INT),
        .o_busy        (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory.
    always_comb begin
        if (imem_addr == 32'd0) imem_data = BOOT_PC;
        else if (imem_addr == 32'd1) imem_data = ISR_PC;
        else imem_data = 32'hC000_0000 | imem_addr;
    end

    // The handler-vector cycle must never see a redirect.
    always @(negedge clk) begin
        if (!rst && o_busy && imem_addr == 32'd1) begin
            assert (!redirect) else $error("redirect during INT_VEC");
        end
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    // Advance one clock (through a rising edge) and settle on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic jump(input logic [31:0] target);
        redirect    = 1'b1;
        redirect_pc = target;
        tick();
        redirect = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (o_busy !== 1'b1 || o_pc !== 32'd0 || o_instruction !== NOP || out_INT !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%0b pc=%h instr=%h int=%0b, required busy=1 pc=0 instr=0 int=0",
                     o_busy, o_pc, o_instruction, out_INT);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_boot();
        // First cycle after release is still BOOT.
        checks++;
        if (o_busy !== 1'b1 || imem_addr !== 32'd0 || o_instruction !== NOP) begin
            errors++;
            $display("FAIL boot_cycle: busy=%0b addr=%h instr=%h, required busy=1 addr=0 instr=0",
                     o_busy, imem_addr, o_instruction);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (o_pc !== BOOT_PC + i || o_instruction !== (32'hC000_0010 + i) || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL boot_seq%0d: pc=%h instr=%h busy=%0b, required pc=%h instr=%h busy=0",
                         i, o_pc, o_instruction, o_busy, BOOT_PC + i, 32'hC000_0010 + i);
            end
        end
    endtask

    task automatic test_stall();
        jump(32'h0000_0020);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (o_pc !== 32'h20 || o_instruction !== 32'hC000_0020) begin
                errors++;
                $display("FAIL stall_hold%0d: pc=%h instr=%h, required pc=00000020 instr=c0000020",
                         i, o_pc, o_instruction);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (o_pc !== 32'h21 || o_instruction !== 32'hC000_0021) begin
            errors++;
            $display("FAIL stall_release: pc=%h instr=%h, required pc=00000021 instr=c0000021",
                     o_pc, o_instruction);
        end
    endtask

    task automatic test_redirect_stall();
        jump(32'h0000_0030);
        stall = 1'b1;
        jump(32'h0000_0080);
        stall = 1'b0;
        #1;
        checks++;
        if (o_pc !== 32'h80 || o_instruction !== 32'hC000_0080) begin
            errors++;
            $display("FAIL redirect_over_stall: pc=%h instr=%h, required pc=00000080 instr=c0000080",
                     o_pc, o_instruction);
        end
    endtask

    task automatic test_interrupt();
        jump(32'h0000_0040);
        in_INT = 1'b1;
        tick();
        in_INT = 1'b0;
        #1;
        checks++;
        if (o_pc !== 32'h41 || out_INT !== 1'b1 || o_instruction !== NOP || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL int_bubble: pc=%h int=%0b instr=%h busy=%0b, required pc=00000041 int=1 instr=0 busy=0",
                     o_pc, out_INT, o_instruction, o_busy);
        end
        tick();
        checks++;
        if (o_busy !== 1'b1 || imem_addr !== 32'd1 || out_INT !== 1'b0 || o_instruction !== NOP) begin
            errors++;
            $display("FAIL int_vec: busy=%0b addr=%h int=%0b instr=%h, required busy=1 addr=1 int=0 instr=0",
                     o_busy, imem_addr, out_INT, o_instruction);
        end
        tick();
        checks++;
        if (o_pc !== ISR_PC || o_instruction !== 32'hC000_0200 || out_INT !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL int_handler: pc=%h instr=%h int=%0b busy=%0b, required pc=00000200 instr=c0000200 int=0 busy=0",
                     o_pc, o_instruction, out_INT, o_busy);
        end
    endtask

    task automatic test_int_merge();
        int bubbles;
        jump(32'h0000_0050);
        stall  = 1'b1;
        in_INT = 1'b1;
        tick();
        in_INT = 1'b0;
        tick();
        in_INT = 1'b1;
        tick();
        in_INT = 1'b0;
        tick();
        checks++;
        if (o_pc !== 32'h50 || out_INT !== 1'b0 || o_instruction !== 32'hC000_0050) begin
            errors++;
            $display("FAIL merge_stalled: pc=%h int=%0b instr=%h, required pc=00000050 int=0 instr=c0000050",
                     o_pc, out_INT, o_instruction);
        end
        stall = 1'b0;
        #1;
        checks++;
        if (o_pc !== 32'h50 || out_INT !== 1'b1 || o_instruction !== NOP) begin
            errors++;
            $display("FAIL merge_bubble: pc=%h int=%0b instr=%h, required pc=00000050 int=1 instr=0",
                     o_pc, out_INT, o_instruction);
        end
        tick();
        tick();
        bubbles = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_INT === 1'b1) bubbles++;
            tick();
        end
        checks++;
        if (bubbles !== 0 || o_pc !== 32'h204) begin
            errors++;
            $display("FAIL merge_single: extra_bubbles=%0d pc=%h, required extra_bubbles=0 pc=00000204",
                     bubbles, o_pc);
        end
    endtask

    task automatic test_wrap();
        jump(32'hFFFF_FFFF);
        checks++;
        if (o_pc !== 32'hFFFF_FFFF || o_instruction !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_top: pc=%h instr=%h, required pc=ffffffff instr=ffffffff", o_pc, o_instruction);
        end
        tick();
        checks++;
        if (o_pc !== 32'd0 || imem_addr !== 32'd0 || o_instruction !== BOOT_PC || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_zero: pc=%h addr=%h instr=%h busy=%0b, required pc=0 addr=0 instr=00000010 busy=0",
                     o_pc, imem_addr, o_instruction, o_busy);
        end
    endtask

    task automatic test_reset_in_intvec();
        int bubbles;
        jump(32'h0000_0060);
        in_INT = 1'b1;
        tick();
        in_INT = 1'b0;
        tick();
        checks++;
        if (o_busy !== 1'b1 || imem_addr !== 32'd1) begin
            errors++;
            $display("FAIL rst_intvec_entry: busy=%0b addr=%h, required busy=1 addr=1", o_busy, imem_addr);
        end
        // Reset here; a request coinciding with reset must be dropped.
        rst    = 1'b1;
        in_INT = 1'b1;
        tick();
        rst    = 1'b0;
        in_INT = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b1 || o_pc !== 32'd0 || imem_addr !== 32'd0 || out_INT !== 1'b0) begin
            errors++;
            $display("FAIL rst_intvec_boot: busy=%0b pc=%h addr=%h int=%0b, required busy=1 pc=0 addr=0 int=0",
                     o_busy, o_pc, imem_addr, out_INT);
        end
        bubbles = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_INT === 1'b1) bubbles++;
        end
        checks++;
        if (bubbles !== 0 || o_pc !== 32'h15) begin
            errors++;
            $display("FAIL rst_intvec_after: bubbles=%0d pc=%h, required bubbles=0 pc=00000015", bubbles, o_pc);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        in_INT      = 1'b0;
        @(negedge clk);
        test_reset();
        test_boot();
        test_stall();
        test_redirect_stall();
        test_interrupt();
        test_int_merge();
        test_wrap();
        test_reset_in_intvec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage of the 32-bit core; sits directly upstream of the fetch/decode pipeline buffer and drives its pc, instruction and INT inputs.
- Owns the PC register and drives the instruction-memory address. Memory read is combinational, one 32-bit word per address.
- Handles boot-vector load, branch redirect, stall and interrupt entry.

Parameters:
- ADDR_W, 32, PC and memory address width
- RESET_VEC_ADDR, 0, memory word holding the boot PC
- INT_VEC_ADDR, 1, memory word holding the interrupt handler PC
- NOP_INSTR, 32'h0000_0000, instruction word emitted as a bubble

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit hold; PC frozen, outputs frozen
- redirect  in  1  taken branch/jump/return from a later stage
- redirect_pc  in  32  target PC for redirect
- in_INT  in  1  external interrupt request, single-cycle pulse
- imem_addr  out  32  instruction memory address, combinational
- imem_data  in  32  instruction memory read data, same cycle
- o_pc  out  32  PC of the instruction presented; return PC on an interrupt bubble
- o_instruction  out  32  fetched instruction or NOP_INSTR
- out_INT  out  1  marks the bubble that carries the interrupt to decode
- o_busy  out  1  high while in BOOT or INT_VEC

Behaviour:
- State machine: BOOT, RUN, INT_VEC. Reset enters BOOT.
- Reset (rst=1 at a clock edge):
  - state=BOOT, pc=0, int_pending=0.
  - Outputs are combinational from state: in BOOT, o_instruction=NOP_INSTR, out_INT=0, o_pc=0, o_busy=1.
- BOOT:
  - imem_addr=RESET_VEC_ADDR.
  - Next edge: pc<=imem_data, state<=RUN.
  - stall, redirect and in_INT are ignored for PC purposes; an in_INT pulse is still latched into int_pending.
- RUN:
  - imem_addr=pc, o_pc=pc, o_instruction=imem_data, out_INT=0, o_busy=0.
  - Next-PC priority, highest first: redirect, stall, interrupt entry, increment.
  - redirect=1: pc<=redirect_pc, ignoring stall. The current output is a wrong-path instruction and is flushed downstream, not here. A pending interrupt stays pending.
  - stall=1 (no redirect): pc holds and all outputs hold value. int_pending is kept.
  - int_pending=1 (no redirect, no stall):
    - This cycle, o_instruction=NOP_INSTR, out_INT=1, o_pc=pc (the return address; the instruction at pc is not consumed).
    - Next edge: state<=INT_VEC, int_pending<=0, pc holds.
  - Otherwise: pc<=pc+1, wrapping modulo 2^32 (32'hFFFF_FFFF goes to 0).
- INT_VEC:
  - imem_addr=INT_VEC_ADDR, o_instruction=NOP_INSTR, out_INT=0, o_pc=pc, o_busy=1.
  - Next edge: pc<=imem_data, state<=RUN.
  - stall is ignored in INT_VEC.
  - A redirect in INT_VEC is ignored; the hazard unit guarantees none, and the bench checks this as an assertion.
- int_pending:
  - Set by in_INT=1 at any edge where rst=0.
  - Cleared only when the interrupt bubble leaves RUN.
  - A second pulse while pending is merged; there is no counting or nesting.
  - in_INT arriving on the same edge the bubble is taken sets pending again, so a second entry follows.
- Reset mid-operation (any state): next state BOOT, pending interrupt discarded.
- Latency:
  - Boot: first real instruction on the 2nd cycle after reset release.
  - Interrupt: request to bubble 1 cycle minimum (pending registered); bubble to first handler instruction 2 cycles.

Test Plan:
- Reset, mem[0]=0x10, mem[0x10..0x12]=A,B,C → cycle 1 NOP/busy; then o_pc=0x10,0x11,0x12 with instructions A,B,C.
- Running at pc=0x20, stall held 3 cycles → o_pc=0x20 and o_instruction held for 3 cycles, then 0x21 follows.
- At pc=0x30, redirect=1 with redirect_pc=0x80 and stall=1 on the same cycle → next o_pc=0x80; stall does not block redirect.
- mem[1]=0x200, in_INT pulse at pc=0x40 → next cycle o_pc=0x41, out_INT=1, o_instruction=NOP. Then one INT_VEC cycle (busy=1, imem_addr=1). Then o_pc=0x200.
- in_INT pulse during stall, then a second pulse before release → exactly one interrupt bubble after stall drops; pc resumes correctly.
- Load pc=32'hFFFF_FFFF via redirect, no stall → following o_pc=0. Assert rst while in INT_VEC → BOOT, out_INT never asserted again.
